// File: rtl/serial_adder_n_bit.sv
// Multi-cycle N-bit adder/subtractor: one SLICE-bit ripple slice per clock,
// with a start/busy/done handshake.
module serial_adder_n_bit #(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             ovf
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] s_reg;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             cout_reg;
  logic             ovf_reg;

  logic [SLICE-1:0] slice_sum;
  logic [SLICE:0]   chain;
  logic [WIDTH-1:0] s_next;

  // Ripple slice: chain[i] is the carry into bit i of the current slice.
  always_comb begin
    chain     = '0;
    slice_sum = '0;
    chain[0]  = carry;
    for (int unsigned i = 0; i < SLICE; i++) begin
      slice_sum[i] = a_reg[i] ^ b_reg[i] ^ chain[i];
      chain[i+1]   = (a_reg[i] & b_reg[i]) | (a_reg[i] & chain[i]) |
                     (b_reg[i] & chain[i]);
    end
  end

  // New slice enters from the MSB side so the last slice lands on top.
  assign s_next = (s_reg >> SLICE) | (WIDTH'(slice_sum) << (WIDTH - SLICE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      s_reg    <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= A;
            b_reg <= sub ? ~B : B;
            carry <= sub ? 1'b1 : Cin;
            cnt   <= '0;
            s_reg <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          s_reg <= s_next;
          a_reg <= a_reg >> SLICE;
          b_reg <= b_reg >> SLICE;
          carry <= chain[SLICE];
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            cout_reg <= chain[SLICE];
            ovf_reg  <= chain[SLICE] ^ chain[SLICE-1];
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign S    = s_reg;
  assign Cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_adder_n_bit.sv
// Directed bench for serial_adder_n_bit: three configurations (8/1, 8/4, 16/16)
// sharing clock, reset and operand buses, each with its own start.
module tb_serial_adder_n_bit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a16, b16;
  logic        cin, sub;
  logic [2:0]  start_v;

  logic [2:0]  busy_v, done_v, cout_v, ovf_v;
  logic [15:0] s_v [3];
  logic [7:0]  s0, s1;
  logic [15:0] s2;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  serial_adder_n_bit #(.WIDTH(8), .SLICE(1)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .A(a16[7:0]), .B(b16[7:0]),
    .Cin(cin), .sub(sub), .busy(busy_v[0]), .done(done_v[0]), .S(s0),
    .Cout(cout_v[0]), .ovf(ovf_v[0])
  );

  serial_adder_n_bit #(.WIDTH(8), .SLICE(4)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .A(a16[7:0]), .B(b16[7:0]),
    .Cin(cin), .sub(sub), .busy(busy_v[1]), .done(done_v[1]), .S(s1),
    .Cout(cout_v[1]), .ovf(ovf_v[1])
  );

  serial_adder_n_bit #(.WIDTH(16), .SLICE(16)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .A(a16), .B(b16),
    .Cin(cin), .sub(sub), .busy(busy_v[2]), .done(done_v[2]), .S(s2),
    .Cout(cout_v[2]), .ovf(ovf_v[2])
  );

  assign s_v[0] = {8'h00, s0};
  assign s_v[1] = {8'h00, s1};
  assign s_v[2] = s2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Runs one operation on instance u; optionally pokes start with junk mid-run.
  task automatic run_op(input string tag, input int u, input int n,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic sb, input logic poke,
                        input logic [15:0] es, input logic ec, input logic eo);
    int cycles = 0;
    int dcnt = 0;
    logic [15:0] got_s = '0;
    logic got_c = 1'b0;
    logic got_o = 1'b0;
    @(negedge clk);
    a16 = a; b16 = b; cin = ci; sub = sb; start_v[u] = 1'b1;
    @(posedge clk); #1;
    start_v[u] = 1'b0;
    a16 = 16'hA5A5; b16 = 16'h5A5A; cin = ~ci; sub = ~sb;
    while (busy_v[u] && cycles < 50) begin
      cycles++;
      if (done_v[u]) begin
        dcnt++;
        got_s = s_v[u]; got_c = cout_v[u]; got_o = ovf_v[u];
      end
      if (poke && cycles == 2) begin
        start_v[u] = 1'b1; a16 = 16'hFFFF; b16 = 16'hFFFF;
      end else begin
        start_v[u] = 1'b0;
      end
      @(posedge clk); #1;
    end
    check({tag, "/busy_cycles"}, cycles, n + 1);
    check({tag, "/done_pulses"}, dcnt, 1);
    check({tag, "/S"}, got_s, es);
    check({tag, "/Cout"}, got_c, ec);
    check({tag, "/ovf"}, got_o, eo);
    check({tag, "/S_held"}, s_v[u], es);
  endtask

  initial begin
    int dseen;
    rst = 1'b1; a16 = '0; b16 = '0; cin = 1'b0; sub = 1'b0; start_v = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset/busy", busy_v, 3'b000);
    check("reset/done", done_v, 3'b000);
    check("reset/S0", s_v[0], 16'h0000);
    check("reset/Cout", cout_v, 3'b000);
    check("reset/ovf", ovf_v, 3'b000);
    rst = 1'b0;

    // WIDTH=8, SLICE=1
    run_op("t1_5A+3C", 0, 8, 16'h005A, 16'h003C, 1'b0, 1'b0, 1'b0, 16'h0096, 1'b0, 1'b1);
    run_op("t2_FF+01", 0, 8, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("t2_7F+00+1", 0, 8, 16'h007F, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b1);
    run_op("t3_10-20", 0, 8, 16'h0010, 16'h0020, 1'b1, 1'b1, 1'b0, 16'h00F0, 1'b0, 1'b0);
    run_op("t3_80-01", 0, 8, 16'h0080, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h007F, 1'b1, 1'b1);

    // WIDTH=8, SLICE=4
    run_op("t4a_5A+3C", 1, 2, 16'h005A, 16'h003C, 1'b0, 1'b0, 1'b0, 16'h0096, 1'b0, 1'b1);
    run_op("t4a_C8+64+1", 1, 2, 16'h00C8, 16'h0064, 1'b1, 1'b0, 1'b0, 16'h002D, 1'b1, 1'b0);
    run_op("t4a_05-07", 1, 2, 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 16'h00FE, 1'b0, 1'b0);
    run_op("t4a_7F-FF", 1, 2, 16'h007F, 16'h00FF, 1'b0, 1'b1, 1'b0, 16'h0080, 1'b0, 1'b1);

    // WIDTH=16, SLICE=16
    run_op("t4b_1234+4321", 2, 1, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("t4b_FFFF+1+1", 2, 1, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0);
    run_op("t4b_8000-1", 2, 1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    run_op("t4b_7000+1000", 2, 1, 16'h7000, 16'h1000, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

    // start during RUN must be ignored
    run_op("t5_poke", 0, 8, 16'h005A, 16'h003C, 1'b0, 1'b0, 1'b1, 16'h0096, 1'b0, 1'b1);

    // reset sampled at RUN edge 3 aborts the operation
    @(negedge clk);
    a16 = 16'h005A; b16 = 16'h003C; cin = 1'b0; sub = 1'b0; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    check("t6/busy_run", busy_v[0], 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t6/partial_S", s_v[0], 16'h0080);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t6/busy_after_rst", busy_v[0], 1'b0);
    check("t6/done_after_rst", done_v[0], 1'b0);
    check("t6/S_after_rst", s_v[0], 16'h0000);
    dseen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done_v[0] || busy_v[0]) dseen++;
      @(posedge clk); #1;
    end
    check("t6/no_done_after_abort", dseen, 0);
    run_op("t6_restart", 0, 8, 16'h005A, 16'h003C, 1'b0, 1'b0, 1'b0, 16'h0096, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
